// File: rtl/ls_rs_if.sv
// Shared op type and the dispatch / CDB / LS-issue bundle of the load-store reservation station.
// The master modport drives requests into the station and the slave modport is the station itself.
package ls_rs_pkg;
   localparam int GPR_SIZE = 64;

   typedef enum logic [1:0] {
      FU_OP_PLUS = 2'd0,
      FU_OP_LDUR = 2'd1,
      FU_OP_STUR = 2'd2,
      FU_OP_NONE = 2'd3
   } fu_op_t;
endpackage

interface ls_rs_if #(
   parameter int ENTRIES   = 4,
   parameter int ROB_IDX_W = 4
) ();
   import ls_rs_pkg::*;

   // Handshake rule for the whole bundle: a dispatch is taken on a rising edge where
   // in_dispatch_valid and out_dispatch_ready are both 1, and an issue happens on an edge where the
   // head is ready and in_fu_ready is 1; out_fu_start then pulses for exactly one cycle.
   logic                         in_dispatch_valid;
   fu_op_t                       in_dispatch_op;
   logic [ROB_IDX_W-1:0]         in_dispatch_dst_rob_index;
   logic                         in_dispatch_a_ready;
   logic                         in_dispatch_b_ready;
   logic [ROB_IDX_W-1:0]         in_dispatch_a_tag;
   logic [ROB_IDX_W-1:0]         in_dispatch_b_tag;
   logic [GPR_SIZE-1:0]          in_dispatch_val_a;
   logic [GPR_SIZE-1:0]          in_dispatch_val_b;
   logic                         out_dispatch_ready;

   logic                         in_cdb_done;
   logic [ROB_IDX_W-1:0]         in_cdb_rob_index;
   logic [GPR_SIZE-1:0]          in_cdb_value;

   logic                         in_fu_ready;
   logic                         out_fu_start;
   fu_op_t                       out_fu_op;
   logic [GPR_SIZE-1:0]          out_fu_val_a;
   logic [GPR_SIZE-1:0]          out_fu_val_b;
   logic [ROB_IDX_W-1:0]         out_fu_dst_rob_index;

   logic                         in_flush;
   logic [$clog2(ENTRIES+1)-1:0] out_count;

   modport master (
      output in_dispatch_valid, in_dispatch_op, in_dispatch_dst_rob_index,
             in_dispatch_a_ready, in_dispatch_b_ready, in_dispatch_a_tag, in_dispatch_b_tag,
             in_dispatch_val_a, in_dispatch_val_b,
             in_cdb_done, in_cdb_rob_index, in_cdb_value, in_fu_ready, in_flush,
      input  out_dispatch_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
             out_fu_dst_rob_index, out_count
   );

   modport slave (
      input  in_dispatch_valid, in_dispatch_op, in_dispatch_dst_rob_index,
             in_dispatch_a_ready, in_dispatch_b_ready, in_dispatch_a_tag, in_dispatch_b_tag,
             in_dispatch_val_a, in_dispatch_val_b,
             in_cdb_done, in_cdb_rob_index, in_cdb_value, in_fu_ready, in_flush,
      output out_dispatch_ready, out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
             out_fu_dst_rob_index, out_count
   );
endinterface

// File: rtl/ls_rs.sv
// In-order load/store reservation station: circular FIFO, CDB wakeup, head-only issue to the LS unit.
// Define LS_RS_CDB_BYPASS_EN to let a head operand woken by the CDB issue on that same edge.
module ls_rs
   import ls_rs_pkg::*;
#(
   parameter int ENTRIES   = 4,
   parameter int ROB_IDX_W = 4
) (
   input  logic   in_clk,
   input  logic   in_rst_n,
   ls_rs_if.slave bus
);

   localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CNT_W = $clog2(ENTRIES + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

   logic [ENTRIES-1:0]   r_valid;
   fu_op_t               r_op    [ENTRIES];
   logic [ROB_IDX_W-1:0] r_dst   [ENTRIES];
   logic [ENTRIES-1:0]   r_a_rdy;
   logic [ENTRIES-1:0]   r_b_rdy;
   logic [ROB_IDX_W-1:0] r_a_tag [ENTRIES];
   logic [ROB_IDX_W-1:0] r_b_tag [ENTRIES];
   logic [GPR_SIZE-1:0]  r_a_val [ENTRIES];
   logic [GPR_SIZE-1:0]  r_b_val [ENTRIES];

   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;

   logic                 r_fu_start;
   fu_op_t               r_fu_op;
   logic [GPR_SIZE-1:0]  r_fu_val_a;
   logic [GPR_SIZE-1:0]  r_fu_val_b;
   logic [ROB_IDX_W-1:0] r_fu_dst;

   logic                 w_not_full;
   logic                 w_push;
   logic                 w_issue;
   logic                 w_disp_a_rdy;
   logic                 w_disp_b_rdy;
   logic [GPR_SIZE-1:0]  w_disp_a_val;
   logic [GPR_SIZE-1:0]  w_disp_b_val;
   logic                 w_head_a_ok;
   logic                 w_head_b_ok;
   logic [GPR_SIZE-1:0]  w_head_a_val;
   logic [GPR_SIZE-1:0]  w_head_b_val;

   // Space is judged from the stored count only; a same-edge pop never frees room for a push.
   assign w_not_full = (r_count < FULL_CNT);
   assign w_push     = bus.in_dispatch_valid && w_not_full;

   // An operand whose producer broadcasts on the dispatch edge is captured straight off the CDB.
   assign w_disp_a_rdy = bus.in_dispatch_a_ready ||
                         (bus.in_cdb_done && (bus.in_cdb_rob_index == bus.in_dispatch_a_tag));
   assign w_disp_b_rdy = bus.in_dispatch_b_ready ||
                         (bus.in_cdb_done && (bus.in_cdb_rob_index == bus.in_dispatch_b_tag));
   assign w_disp_a_val = bus.in_dispatch_a_ready ? bus.in_dispatch_val_a : bus.in_cdb_value;
   assign w_disp_b_val = bus.in_dispatch_b_ready ? bus.in_dispatch_val_b : bus.in_cdb_value;

`ifdef LS_RS_CDB_BYPASS_EN
   logic w_head_a_hit;
   logic w_head_b_hit;

   assign w_head_a_hit = bus.in_cdb_done && (r_a_tag[r_head] == bus.in_cdb_rob_index);
   assign w_head_b_hit = bus.in_cdb_done && (r_b_tag[r_head] == bus.in_cdb_rob_index);
   assign w_head_a_ok  = r_a_rdy[r_head] || w_head_a_hit;
   assign w_head_b_ok  = r_b_rdy[r_head] || w_head_b_hit;
   assign w_head_a_val = r_a_rdy[r_head] ? r_a_val[r_head] : bus.in_cdb_value;
   assign w_head_b_val = r_b_rdy[r_head] ? r_b_val[r_head] : bus.in_cdb_value;
`else
   assign w_head_a_ok  = r_a_rdy[r_head];
   assign w_head_b_ok  = r_b_rdy[r_head];
   assign w_head_a_val = r_a_val[r_head];
   assign w_head_b_val = r_b_val[r_head];
`endif

   assign w_issue = r_valid[r_head] && w_head_a_ok && w_head_b_ok && bus.in_fu_ready;

   // Entry storage: dispatch write at the tail, pop at the head, CDB wakeup everywhere else.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_valid <= '0;
         r_a_rdy <= '0;
         r_b_rdy <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_op[i]    <= FU_OP_PLUS;
            r_dst[i]   <= '0;
            r_a_tag[i] <= '0;
            r_b_tag[i] <= '0;
            r_a_val[i] <= '0;
            r_b_val[i] <= '0;
         end
      end else if (bus.in_flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_push && (r_tail == PTR_W'(i))) begin
               r_valid[i] <= 1'b1;
               r_op[i]    <= bus.in_dispatch_op;
               r_dst[i]   <= bus.in_dispatch_dst_rob_index;
               r_a_tag[i] <= bus.in_dispatch_a_tag;
               r_b_tag[i] <= bus.in_dispatch_b_tag;
               r_a_rdy[i] <= w_disp_a_rdy;
               r_b_rdy[i] <= w_disp_b_rdy;
               r_a_val[i] <= w_disp_a_val;
               r_b_val[i] <= w_disp_b_val;
            end else begin
               if (w_issue && (r_head == PTR_W'(i))) begin
                  r_valid[i] <= 1'b0;
               end
               if (r_valid[i] && !r_a_rdy[i] && bus.in_cdb_done &&
                   (r_a_tag[i] == bus.in_cdb_rob_index)) begin
                  r_a_rdy[i] <= 1'b1;
                  r_a_val[i] <= bus.in_cdb_value;
               end
               if (r_valid[i] && !r_b_rdy[i] && bus.in_cdb_done &&
                   (r_b_tag[i] == bus.in_cdb_rob_index)) begin
                  r_b_rdy[i] <= 1'b1;
                  r_b_val[i] <= bus.in_cdb_value;
               end
            end
         end
      end
   end

   // Pointers wrap naturally because ENTRIES is a power of two.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.in_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_issue) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue register: payload only reloads on an issue, so it holds between starts.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_fu_start <= 1'b0;
         r_fu_op    <= FU_OP_PLUS;
         r_fu_val_a <= '0;
         r_fu_val_b <= '0;
         r_fu_dst   <= '0;
      end else if (bus.in_flush) begin
         r_fu_start <= 1'b0;
      end else begin
         r_fu_start <= w_issue;
         if (w_issue) begin
            r_fu_op    <= r_op[r_head];
            r_fu_val_a <= w_head_a_val;
            r_fu_val_b <= w_head_b_val;
            r_fu_dst   <= r_dst[r_head];
         end
      end
   end

   assign bus.out_dispatch_ready   = w_not_full;
   assign bus.out_count            = r_count;
   assign bus.out_fu_start         = r_fu_start;
   assign bus.out_fu_op            = r_fu_op;
   assign bus.out_fu_val_a         = r_fu_val_a;
   assign bus.out_fu_val_b         = r_fu_val_b;
   assign bus.out_fu_dst_rob_index = r_fu_dst;

endmodule

// File: tb/tb_ls_rs.sv
// Directed bench for ls_rs: expected issues go into a queue at dispatch, a negedge monitor pops them.
// Build with LS_RS_CDB_BYPASS_EN to match a bypass-enabled station.
module tb_ls_rs;
   import ls_rs_pkg::*;

   localparam int ENTRIES   = 4;
   localparam int ROB_IDX_W = 4;
   localparam int W         = 2 + GPR_SIZE + GPR_SIZE + ROB_IDX_W;

   logic in_clk;
   logic in_rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [W-1:0] exp_q[$];

   ls_rs_if #(.ENTRIES(ENTRIES), .ROB_IDX_W(ROB_IDX_W)) bus ();

   ls_rs #(.ENTRIES(ENTRIES), .ROB_IDX_W(ROB_IDX_W)) dut (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .bus      (bus)
   );

   // clock / reset
   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got no end, required end");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [W-1:0] pack(input fu_op_t op, input logic [GPR_SIZE-1:0] a,
                                         input logic [GPR_SIZE-1:0] b,
                                         input logic [ROB_IDX_W-1:0] dst);
      return {op, a, b, dst};
   endfunction

   // scoreboard monitor
   always @(negedge in_clk) begin
      if (in_rst_n && bus.out_fu_start) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: got start with op=%0d a=%h b=%h dst=%0d, required no issue",
                     bus.out_fu_op, bus.out_fu_val_a, bus.out_fu_val_b, bus.out_fu_dst_rob_index);
         end else begin
            logic [W-1:0] exp_v;
            logic [W-1:0] got_v;
            exp_v = exp_q.pop_front();
            got_v = pack(bus.out_fu_op, bus.out_fu_val_a, bus.out_fu_val_b, bus.out_fu_dst_rob_index);
            if (got_v !== exp_v) begin
               n_fail++;
               $display("FAIL issue_payload: got %h, required %h", got_v, exp_v);
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.in_dispatch_valid         = 1'b0;
      bus.in_dispatch_op            = FU_OP_LDUR;
      bus.in_dispatch_dst_rob_index = '0;
      bus.in_dispatch_a_ready       = 1'b0;
      bus.in_dispatch_b_ready       = 1'b0;
      bus.in_dispatch_a_tag         = '0;
      bus.in_dispatch_b_tag         = '0;
      bus.in_dispatch_val_a         = '0;
      bus.in_dispatch_val_b         = '0;
      bus.in_cdb_done               = 1'b0;
      bus.in_cdb_rob_index          = '0;
      bus.in_cdb_value              = '0;
      bus.in_fu_ready               = 1'b0;
      bus.in_flush                  = 1'b0;
   endtask

   task automatic dispatch(input fu_op_t op, input logic [3:0] dst,
                           input logic a_rdy, input logic [3:0] a_tag, input logic [63:0] a_val,
                           input logic b_rdy, input logic [3:0] b_tag, input logic [63:0] b_val,
                           input logic exp_issue, input logic [63:0] exp_a, input logic [63:0] exp_b);
      bus.in_dispatch_valid         = 1'b1;
      bus.in_dispatch_op            = op;
      bus.in_dispatch_dst_rob_index = dst;
      bus.in_dispatch_a_ready       = a_rdy;
      bus.in_dispatch_a_tag         = a_tag;
      bus.in_dispatch_val_a         = a_val;
      bus.in_dispatch_b_ready       = b_rdy;
      bus.in_dispatch_b_tag         = b_tag;
      bus.in_dispatch_val_b         = b_val;
      if (exp_issue) exp_q.push_back(pack(op, exp_a, exp_b, dst));
      step();
      bus.in_dispatch_valid = 1'b0;
   endtask

   task automatic dispatch_rdy(input fu_op_t op, input logic [3:0] dst,
                               input logic [63:0] a, input logic [63:0] b, input logic exp_issue);
      dispatch(op, dst, 1'b1, 4'd0, a, 1'b1, 4'd0, b, exp_issue, a, b);
   endtask

   // directed sequence
   initial begin
      in_rst_n = 1'b0;
      clear_inputs();
      repeat (3) step();
      check("reset_count", 64'(bus.out_count), 64'd0);
      check("reset_disp_ready", 64'(bus.out_dispatch_ready), 64'd1);
      check("reset_start", 64'(bus.out_fu_start), 64'd0);
      check("reset_op", 64'(bus.out_fu_op), 64'(FU_OP_PLUS));
      check("reset_val_a", bus.out_fu_val_a, 64'd0);
      check("reset_val_b", bus.out_fu_val_b, 64'd0);
      check("reset_dst", 64'(bus.out_fu_dst_rob_index), 64'd0);
      in_rst_n = 1'b1;
      step();
      check("post_reset_start", 64'(bus.out_fu_start), 64'd0);

      // single ready LDUR: dispatch edge N, issue edge N+1
      bus.in_fu_ready = 1'b1;
      dispatch_rdy(FU_OP_LDUR, 4'd3, 64'h100, 64'h0, 1'b1);
      check("t1_start_n", 64'(bus.out_fu_start), 64'd0);
      check("t1_count_n", 64'(bus.out_count), 64'd1);
      step();
      check("t1_start_n1", 64'(bus.out_fu_start), 64'd1);
      check("t1_count_n1", 64'(bus.out_count), 64'd0);
      step();
      check("t1_start_pulse", 64'(bus.out_fu_start), 64'd0);
      check("t1_hold_val_a", bus.out_fu_val_a, 64'h100);

      // fill to full, fifth dispatch ignored, drain in order
      bus.in_fu_ready = 1'b0;
      dispatch_rdy(FU_OP_LDUR, 4'd0, 64'h10, 64'h0,  1'b1);
      dispatch_rdy(FU_OP_STUR, 4'd1, 64'h20, 64'h21, 1'b1);
      dispatch_rdy(FU_OP_LDUR, 4'd2, 64'h30, 64'h0,  1'b1);
      dispatch_rdy(FU_OP_STUR, 4'd4, 64'h40, 64'h41, 1'b1);
      check("t2_full_count", 64'(bus.out_count), 64'd4);
      check("t2_full_ready", 64'(bus.out_dispatch_ready), 64'd0);
      dispatch_rdy(FU_OP_LDUR, 4'd5, 64'h50, 64'h0, 1'b0);
      check("t2_ignored_count", 64'(bus.out_count), 64'd4);
      check("t2_no_start", 64'(bus.out_fu_start), 64'd0);
      bus.in_fu_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t2_drain_start", 64'(bus.out_fu_start), 64'd1);
         check("t2_drain_count", 64'(bus.out_count), 64'(3 - k));
      end
      step();
      check("t2_drained_start", 64'(bus.out_fu_start), 64'd0);

      // STUR waiting on b tag 5, woken by CDB
      dispatch(FU_OP_STUR, 4'd6, 1'b1, 4'd0, 64'h200, 1'b0, 4'd5, 64'h0, 1'b1, 64'h200, 64'hDEAD);
      check("t3_count", 64'(bus.out_count), 64'd1);
      step();
      check("t3_stall_start", 64'(bus.out_fu_start), 64'd0);
      bus.in_cdb_done      = 1'b1;
      bus.in_cdb_rob_index = 4'd5;
      bus.in_cdb_value     = 64'hDEAD;
      step();
      bus.in_cdb_done = 1'b0;
`ifdef LS_RS_CDB_BYPASS_EN
      check("t3_bypass_start", 64'(bus.out_fu_start), 64'd1);
      check("t3_bypass_count", 64'(bus.out_count), 64'd0);
`else
      check("t3_wake_start", 64'(bus.out_fu_start), 64'd0);
      check("t3_wake_count", 64'(bus.out_count), 64'd1);
      step();
      check("t3_late_start", 64'(bus.out_fu_start), 64'd1);
      check("t3_late_count", 64'(bus.out_count), 64'd0);
`endif
      step();

      // dispatch-edge CDB capture of tag 2
      bus.in_cdb_done      = 1'b1;
      bus.in_cdb_rob_index = 4'd2;
      bus.in_cdb_value     = 64'd7;
      dispatch(FU_OP_LDUR, 4'd9, 1'b0, 4'd2, 64'h55, 1'b1, 4'd0, 64'h0, 1'b1, 64'd7, 64'h0);
      bus.in_cdb_done = 1'b0;
      check("t4_count", 64'(bus.out_count), 64'd1);
      step();
      check("t4_start", 64'(bus.out_fu_start), 64'd1);
      check("t4_count_after", 64'(bus.out_count), 64'd0);
      step();

      // flush beats simultaneous dispatch and ready head
      bus.in_fu_ready = 1'b0;
      dispatch_rdy(FU_OP_LDUR, 4'd1, 64'h300, 64'h0, 1'b0);
      dispatch_rdy(FU_OP_STUR, 4'd2, 64'h310, 64'h1, 1'b0);
      dispatch_rdy(FU_OP_LDUR, 4'd3, 64'h320, 64'h0, 1'b0);
      check("t5_count_before", 64'(bus.out_count), 64'd3);
      bus.in_fu_ready = 1'b1;
      bus.in_flush    = 1'b1;
      dispatch_rdy(FU_OP_LDUR, 4'd4, 64'h330, 64'h0, 1'b0);
      bus.in_flush = 1'b0;
      check("t5_flush_count", 64'(bus.out_count), 64'd0);
      check("t5_flush_start", 64'(bus.out_fu_start), 64'd0);
      check("t5_flush_ready", 64'(bus.out_dispatch_ready), 64'd1);
      step();
      check("t5_after_start", 64'(bus.out_fu_start), 64'd0);

      // ten push/pop pairs across the pointer wrap
      dispatch_rdy(FU_OP_LDUR, 4'd0, 64'h1000, 64'h2000, 1'b1);
      check("t6_prime_count", 64'(bus.out_count), 64'd1);
      for (int i = 1; i <= 10; i++) begin
         dispatch_rdy((i % 2) ? FU_OP_STUR : FU_OP_LDUR, 4'(i), 64'h1000 + 64'(i),
                      64'h2000 + 64'(i), 1'b1);
         check("t6_pair_start", 64'(bus.out_fu_start), 64'd1);
         check("t6_pair_count", 64'(bus.out_count), 64'd1);
      end
      step();
      check("t6_last_start", 64'(bus.out_fu_start), 64'd1);
      check("t6_last_count", 64'(bus.out_count), 64'd0);
      step();
      check("t6_idle_start", 64'(bus.out_fu_start), 64'd0);

      // reset mid-operation discards queued work
      bus.in_fu_ready = 1'b0;
      dispatch_rdy(FU_OP_LDUR, 4'd7, 64'h400, 64'h0, 1'b0);
      dispatch_rdy(FU_OP_STUR, 4'd8, 64'h410, 64'h1, 1'b0);
      check("t7_count_before", 64'(bus.out_count), 64'd2);
      #2 in_rst_n = 1'b0;
      #1;
      check("t7_async_count", 64'(bus.out_count), 64'd0);
      check("t7_async_ready", 64'(bus.out_dispatch_ready), 64'd1);
      check("t7_async_val_a", bus.out_fu_val_a, 64'd0);
      check("t7_async_op", 64'(bus.out_fu_op), 64'(FU_OP_PLUS));
      step();
      in_rst_n        = 1'b1;
      bus.in_fu_ready = 1'b1;
      step();
      check("t7_no_issue", 64'(bus.out_fu_start), 64'd0);
      check("t7_count_after", 64'(bus.out_count), 64'd0);

      repeat (2) step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ls_rs.md
LS_RS -- requirements
Module: ls_rs

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, queue depth; power of two, at least 2.
REQ-002 SHALL have parameter ROB_IDX_W, default 4, ROB index width.
REQ-003 SHALL have port in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port in_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_dispatch_valid  input  1  dispatch request.
REQ-006 SHALL have port in_dispatch_op  input  fu_op_t  FU_OP_LDUR or FU_OP_STUR.
REQ-007 SHALL have port in_dispatch_dst_rob_index  input  ROB_IDX_W  destination ROB slot.
REQ-008 SHALL have ports in_dispatch_{a,b}_ready, in_dispatch_{a,b}_tag, in_dispatch_val_{a,b}  input  1 / ROB_IDX_W / GPR_SIZE  per-operand ready flag, producer ROB tag, value; a = address, b = store data.
REQ-009 SHALL have port out_dispatch_ready  output  1  queue not full.
REQ-010 SHALL have ports in_cdb_done, in_cdb_rob_index, in_cdb_value  input  1 / ROB_IDX_W / GPR_SIZE  FU result broadcast.
REQ-011 SHALL have port in_fu_ready  input  1  LS unit accepts a start this cycle.
REQ-012 SHALL have ports out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b, out_fu_dst_rob_index  output  1 / fu_op_t / GPR_SIZE / GPR_SIZE / ROB_IDX_W  issue to LS unit, all registered.
REQ-013 SHALL have port in_flush  input  1  mispredict squash.
REQ-014 SHALL have port out_count  output  $clog2(ENTRIES+1)  occupied entries.

Function
REQ-015 SHALL store entries in a circular FIFO (head/tail pointers wrap modulo ENTRIES); issue strictly in dispatch order, head only.
REQ-016 SHALL accept dispatch on an edge where in_dispatch_valid and out_dispatch_ready are both 1; dispatch while not ready SHALL be ignored.
REQ-017 SHALL drive out_dispatch_ready = (out_count < ENTRIES), from stored count only; a pop in the same cycle does not free space for a push.
REQ-018 SHALL, at dispatch, mark an operand ready and take in_cdb_value when in_cdb_done=1 and in_cdb_rob_index equals its tag, even if in_dispatch_x_ready=0.
REQ-019 SHALL, each edge, capture in_cdb_value into every valid not-ready operand whose tag equals in_cdb_rob_index while in_cdb_done=1.
REQ-020 SHALL issue the head on an edge where it is valid, both operands are ready, and in_fu_ready=1: register out_fu_* from the head, set out_fu_start=1, pop.
REQ-021 SHALL hold out_fu_start high exactly one cycle per issue, at most one issue per cycle; out_fu_val/op/index SHALL hold their last values while out_fu_start=0.
REQ-022 SHALL give a dispatched fully-ready op into an empty queue out_fu_start=1 in the cycle after the next edge (dispatch edge N, issue edge N+1).
REQ-023 SHALL support push and pop on the same edge; out_count unchanged.
REQ-024 SHALL, on in_flush=1 at an edge, invalidate all entries, zero pointers and count, force out_fu_start=0; flush overrides simultaneous dispatch and issue.

Reset
REQ-025 SHALL, while in_rst_n=0, asynchronously clear all entries, pointers, out_count=0, out_fu_start=0, out_fu_op=FU_OP_PLUS, out_fu_val_a=0, out_fu_val_b=0, out_fu_dst_rob_index=0; out_dispatch_ready=1.
REQ-026 SHALL discard in-flight state on reset mid-operation; no issue on the first edge after deassertion unless dispatched then.

Configuration
REQ-027 SHALL, with LS_RS_CDB_BYPASS_EN defined, treat a head operand as ready for REQ-020 when its tag matches an active CDB broadcast on that edge and issue with in_cdb_value (wake and issue same edge).
REQ-028 SHALL, without LS_RS_CDB_BYPASS_EN, issue only from stored-ready operands; a head woken at edge K issues no earlier than edge K+1.

Verification
REQ-029 SHALL test: reset, dispatch LDUR a=0x100 ready, dst=3, in_fu_ready=1 -> out_fu_start one cycle later with val_a=0x100, dst=3, out_count back to 0.
REQ-030 SHALL test: dispatch 4 ops with in_fu_ready=0 -> out_dispatch_ready=0, out_count=4; 5th dispatch ignored; raise in_fu_ready -> 4 issues in order on consecutive cycles.
REQ-031 SHALL test: STUR with b tag=5 not ready at head; CDB done idx=5 value=0xDEAD -> issue with val_b=0xDEAD at the CDB edge (bypass) or one edge later (no bypass).
REQ-032 SHALL test: dispatch with tag=2 in same cycle as CDB idx=2 value=7 -> operand captured as 7, no hang.
REQ-033 SHALL test: 3 entries queued, in_flush with simultaneous dispatch and ready head -> out_count=0, no out_fu_start next cycle.
REQ-034 SHALL test: 10 push/pop pairs across pointer wrap at ENTRIES=4 -> issue order equals dispatch order, out_count stable.
